cam_pixel_packer: RTL and testbench

CAM_PIXEL_PACKER -- requirements
Module: cam_pixel_packer

---
 rtl/cam_pixel_packer_if.sv | 26 ++
 rtl/cam_pixel_packer.sv | 349 ++++++++++++++++++++++++++++++++++
 tb/tb_cam_pixel_packer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cam_pixel_packer_if.sv
// Camera-side pixel bus and packed-word stream for cam_pixel_packer.
// master: the packer (consumes camera signals, drives the word stream).
// slave : the environment (drives camera signals, consumes the word stream).
`timescale 1ns/1ps
interface cam_pixel_packer_if #(
    parameter int PIX_W = 10
) ();
    logic [PIX_W-1:0] cam_d;
    logic             cam_fval;
    logic             cam_lval;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sof;
    logic             out_eol;

    modport master (
        input  cam_d, cam_fval, cam_lval, out_ready,
        output out_data, out_valid, out_sof, out_eol
    );

    modport slave (
        output cam_d, cam_fval, cam_lval, out_ready,
        input  out_data, out_valid, out_sof, out_eol
    );
endinterface

// File: rtl/cam_pixel_packer.sv
// cam_pixel_packer: packs three 10-bit camera pixels per 32-bit word
// ([9:0] first, [19:10] second, [29:20] third, [31:30] zero), tags each
// word with start-of-frame / end-of-line, and buffers the words in a
// FIFO_DEPTH-entry FIFO behind a valid/ready handshake.
// Optional feature: define CAM_PACKER_STATS_EN to build the line_count /
// pix_count statistics; otherwise both outputs are tied to zero.
`timescale 1ns/1ps
module cam_pixel_packer #(
    parameter int PIX_W      = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    cam_pixel_packer_if.master bus,
    output logic               overflow,
    output logic [15:0]        line_count,
    output logic [15:0]        pix_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = 3 * PIX_W;      // packed pixel payload
    localparam int EW = WW + 2;         // payload plus sof and eol flags
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LINE = 2'd1,
        LINE      = 2'd2,
        FLUSH     = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input registers and edge detection
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] d_q, d_d;
    logic             fval_q, fval_d;
    logic             lval_q, lval_d;
    logic             fval_p_q, fval_p_d;
    logic             lval_p_q, lval_p_d;
    logic             in_vld_q, in_vld_d;   // fval_q holds a real sample
    logic             p_vld_q, p_vld_d;     // fval_p_q holds a real sample

    // Next values of the input stage and the one-cycle-old copies.
    always_comb begin
        d_d      = bus.cam_d;
        fval_d   = bus.cam_fval;
        lval_d   = bus.cam_lval;
        fval_p_d = fval_q;
        lval_p_d = lval_q;
        in_vld_d = 1'b1;
        p_vld_d  = in_vld_q;
    end

    // Input stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_q      <= {PIX_W{1'b0}};
            fval_q   <= 1'b0;
            lval_q   <= 1'b0;
            fval_p_q <= 1'b0;
            lval_p_q <= 1'b0;
            in_vld_q <= 1'b0;
            p_vld_q  <= 1'b0;
        end else begin
            d_q      <= d_d;
            fval_q   <= fval_d;
            lval_q   <= lval_d;
            fval_p_q <= fval_p_d;
            lval_p_q <= lval_p_d;
            in_vld_q <= in_vld_d;
            p_vld_q  <= p_vld_d;
        end
    end

    // A rising fval only counts when both samples postdate reset, so a
    // frame already running when reset is released is never picked up.
    logic fval_rise_s;
    logic lval_rise_s;
    logic line_more_s;
    assign fval_rise_s = fval_q & ~fval_p_q & p_vld_q;
    assign lval_rise_s = lval_q & ~lval_p_q;
    // Look-ahead at the sample entering the input stage: if it no longer
    // belongs to the line, the word completed now is the line's last.
    assign line_more_s = bus.cam_lval & bus.cam_fval;

    // ------------------------------------------------------------------
    // Line state machine and pixel accumulator
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [PIX_W-1:0] slot0_q, slot0_d;
    logic [PIX_W-1:0] slot1_q, slot1_d;
    logic [1:0]       cnt_q, cnt_d;         // pixels held in slot0/slot1
    logic             sof_pend_q, sof_pend_d;
    logic             take_s;
    logic             wr_s;
    logic             wr_eol_s;
    logic [WW-1:0]    wr_word_s;

    // Next state, pixel capture and word formation.
    always_comb begin
        state_d    = state_q;
        slot0_d    = slot0_q;
        slot1_d    = slot1_q;
        cnt_d      = cnt_q;
        sof_pend_d = sof_pend_q;
        take_s     = 1'b0;
        wr_s       = 1'b0;
        wr_eol_s   = 1'b0;
        wr_word_s  = {WW{1'b0}};
        case (state_q)
            IDLE: begin
                if (fval_rise_s) begin
                    state_d    = WAIT_LINE;
                    sof_pend_d = 1'b1;
                end else begin
                    state_d    = IDLE;
                end
            end
            WAIT_LINE: begin
                if (!fval_q) begin
                    state_d = IDLE;
                end else if (lval_rise_s) begin
                    state_d = LINE;
                    take_s  = 1'b1;
                end else begin
                    state_d = WAIT_LINE;
                end
            end
            LINE: begin
                // fval dropping mid-line ends the line just like lval.
                if (!lval_q || !fval_q) begin
                    state_d = FLUSH;
                end else begin
                    take_s  = 1'b1;
                end
            end
            FLUSH: begin
                // Slots beyond cnt_q are already zero, so the partial
                // word can be emitted as-is.
                if (cnt_q != 2'd0) begin
                    wr_s      = 1'b1;
                    wr_eol_s  = 1'b1;
                    wr_word_s = {{PIX_W{1'b0}}, slot1_q, slot0_q};
                end else begin
                    wr_s      = 1'b0;
                end
                cnt_d   = 2'd0;
                slot0_d = {PIX_W{1'b0}};
                slot1_d = {PIX_W{1'b0}};
                state_d = fval_q ? WAIT_LINE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take_s) begin
            case (cnt_q)
                2'd0: begin
                    slot0_d = d_q;
                    cnt_d   = 2'd1;
                end
                2'd1: begin
                    slot1_d = d_q;
                    cnt_d   = 2'd2;
                end
                default: begin
                    wr_s      = 1'b1;
                    wr_eol_s  = ~line_more_s;
                    wr_word_s = {d_q, slot1_q, slot0_q};
                    cnt_d     = 2'd0;
                    slot0_d   = {PIX_W{1'b0}};
                    slot1_d   = {PIX_W{1'b0}};
                end
            endcase
        end else begin
            cnt_d = cnt_d;
        end

        if (wr_s) begin
            sof_pend_d = 1'b0;
        end else begin
            sof_pend_d = sof_pend_d;
        end
    end

    // State machine and accumulator registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            slot0_q    <= {PIX_W{1'b0}};
            slot1_q    <= {PIX_W{1'b0}};
            cnt_q      <= 2'd0;
            sof_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            cnt_q      <= cnt_d;
            sof_pend_q <= sof_pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO: entry = {sof, eol, payload}
    // ------------------------------------------------------------------
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          valid_s, full_s, rd_s, push_s, drop_s;
    logic [EW-1:0] head_s;

    assign valid_s = (count_q != {CW{1'b0}});
    assign full_s  = (count_q == DEPTH_C);
    assign rd_s    = valid_s & bus.out_ready;
    // A full FIFO still accepts a write when a read frees a slot this cycle.
    assign push_s  = wr_s & (~full_s | rd_s);
    assign drop_s  = wr_s & full_s & ~rd_s;
    assign head_s  = mem_q[rd_ptr_q];

    // FIFO pointer, occupancy, storage and overflow next-state.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | drop_s;
        if (push_s) begin
            mem_d[wr_ptr_q] = {sof_pend_q, wr_eol_s, wr_word_s};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end
        if (rd_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, rd_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; contents are don't-care until written, outputs are
    // masked by valid so no reset is needed here.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.out_valid = valid_s;
    assign bus.out_data  = valid_s ? {{(32-WW){1'b0}}, head_s[WW-1:0]} : 32'd0;
    assign bus.out_sof   = valid_s & head_s[EW-1];
    assign bus.out_eol   = valid_s & head_s[EW-2];
    assign overflow      = ovf_q;

    // ------------------------------------------------------------------
    // Frame statistics
    // ------------------------------------------------------------------
`ifdef CAM_PACKER_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] line_pix_q, line_pix_d;
    logic [15:0] lines_q, lines_d;
    logic [15:0] pix_count_q, pix_count_d;
    logic [15:0] line_count_q, line_count_d;

    // Count pixels per line and lines per frame; publish at line/frame end.
    always_comb begin
        line_pix_d   = line_pix_q;
        lines_d      = lines_q;
        pix_count_d  = pix_count_q;
        line_count_d = line_count_q;
        if (take_s) begin
            line_pix_d = (state_q == WAIT_LINE) ? 16'd1 : sat_inc(line_pix_q);
        end else begin
            line_pix_d = line_pix_q;
        end
        case (state_q)
            IDLE: begin
                lines_d = 16'd0;
            end
            WAIT_LINE: begin
                if (!fval_q) begin
                    line_count_d = lines_q;
                    lines_d      = 16'd0;
                end else begin
                    lines_d      = lines_q;
                end
            end
            FLUSH: begin
                pix_count_d = line_pix_q;
                if (!fval_q) begin
                    line_count_d = sat_inc(lines_q);
                    lines_d      = 16'd0;
                end else begin
                    lines_d      = sat_inc(lines_q);
                end
            end
            default: begin
                lines_d = lines_q;
            end
        endcase
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_pix_q   <= 16'd0;
            lines_q      <= 16'd0;
            pix_count_q  <= 16'd0;
            line_count_q <= 16'd0;
        end else begin
            line_pix_q   <= line_pix_d;
            lines_q      <= lines_d;
            pix_count_q  <= pix_count_d;
            line_count_q <= line_count_d;
        end
    end

    assign pix_count  = pix_count_q;
    assign line_count = line_count_q;
`else
    assign pix_count  = 16'd0;
    assign line_count = 16'd0;
`endif

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Directed bench for cam_pixel_packer (FIFO_DEPTH = 8). Expected words use
// the layout [9:0] first pixel, [19:10] second, [29:20] third.
`timescale 1ns/1ps
module tb_cam_pixel_packer;
`ifdef CAM_PACKER_STATS_EN
    localparam bit STATS_C = 1'b1;
`else
    localparam bit STATS_C = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        overflow;
    logic [15:0] line_count;
    logic [15:0] pix_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [33:0] cap_q [$];   // {sof, eol, data} of each accepted word

    cam_pixel_packer_if #(.PIX_W(10)) bus_if ();

    cam_pixel_packer #(.PIX_W(10), .FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_if),
        .overflow   (overflow),
        .line_count (line_count),
        .pix_count  (pix_count)
    );

    always #5 clk = ~clk;

    // Record every word that will transfer on the coming rising edge.
    always @(negedge clk) begin
        if (!reset && bus_if.out_valid && bus_if.out_ready) begin
            cap_q.push_back({bus_if.out_sof, bus_if.out_eol, bus_if.out_data});
        end
    end

    function automatic logic [33:0] cap_at(input int i);
        if (i < cap_q.size()) return cap_q[i];
        else return 34'h3_FFFF_FFFF;
    endfunction

    function automatic logic [31:0] pack3(input int a, input int b, input int c);
        logic [9:0] pa, pb, pc;
        pa = 10'(a);
        pb = 10'(b);
        pc = 10'(c);
        return {2'b00, pc, pb, pa};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic fval);
        reset             = 1'b1;
        bus_if.cam_fval   = fval;
        bus_if.cam_lval   = 1'b0;
        bus_if.cam_d      = 10'd0;
        bus_if.out_ready  = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        step();
    endtask

    task automatic frame_start();
        bus_if.cam_fval = 1'b1;
        repeat (3) step();
    endtask

    task automatic frame_end();
        bus_if.cam_fval = 1'b0;
        repeat (4) step();
    endtask

    // n pixels base, base+1, ...; optional one-cycle out_ready pulse on the
    // cycle the line's final full word is written.
    task automatic send_line(input int n, input int base, input bit pulse_rdy);
        for (int i = 0; i < n; i++) begin
            bus_if.cam_lval = 1'b1;
            bus_if.cam_d    = 10'(base + i);
            step();
        end
        bus_if.cam_lval = 1'b0;
        bus_if.cam_d    = 10'd0;
        if (pulse_rdy) bus_if.out_ready = 1'b1;
        step();
        if (pulse_rdy) bus_if.out_ready = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset(1'b0);
        chk("rst_valid",  {63'd0, bus_if.out_valid}, 64'd0);
        chk("rst_data",   {32'd0, bus_if.out_data},  64'd0);
        chk("rst_sof",    {63'd0, bus_if.out_sof},   64'd0);
        chk("rst_eol",    {63'd0, bus_if.out_eol},   64'd0);
        chk("rst_ovf",    {63'd0, overflow},         64'd0);
        chk("rst_lcnt",   {48'd0, line_count},       64'd0);
        chk("rst_pcnt",   {48'd0, pix_count},        64'd0);

        // ---------------- 6-pixel line ----------------
        bus_if.out_ready = 1'b1;
        cap_q.delete();
        frame_start();
        send_line(6, 1, 1'b0);
        frame_end();
        chk("l6_nwords", 64'(cap_q.size()), 64'd2);
        chk("l6_w0",     {32'd0, cap_at(0)}, {30'd0, 1'b1, 1'b0, 32'h0030_0801});
        chk("l6_w1",     {32'd0, cap_at(1)}, {30'd0, 1'b0, 1'b1, 32'h0060_1404});
        chk("l6_pcnt",   {48'd0, pix_count},  STATS_C ? 64'd6 : 64'd0);
        chk("l6_lcnt",   {48'd0, line_count}, STATS_C ? 64'd1 : 64'd0);

        // ---------------- 7-pixel line (partial word) ----------------
        cap_q.delete();
        frame_start();
        send_line(7, 16, 1'b0);
        frame_end();
        chk("l7_nwords", 64'(cap_q.size()), 64'd3);
        chk("l7_w0",     {32'd0, cap_at(0)}, {30'd0, 1'b1, 1'b0, 32'h0120_4410});
        chk("l7_w1",     {32'd0, cap_at(1)}, {30'd0, 1'b0, 1'b0, 32'h0150_5013});
        chk("l7_w2",     {32'd0, cap_at(2)}, {30'd0, 1'b0, 1'b1, 32'h0000_0016});
        chk("l7_pcnt",   {48'd0, pix_count}, STATS_C ? 64'd7 : 64'd0);

        // ---------------- frame of 4 lines x 9 pixels ----------------
        cap_q.delete();
        frame_start();
        for (int l = 0; l < 4; l++) send_line(9, 256 + 16 * l, 1'b0);
        frame_end();
        chk("f4_nwords", 64'(cap_q.size()), 64'd12);
        chk("f4_w0",     {32'd0, cap_at(0)},  {30'd0, 1'b1, 1'b0, pack3(256, 257, 258)});
        chk("f4_w2",     {32'd0, cap_at(2)},  {30'd0, 1'b0, 1'b1, pack3(262, 263, 264)});
        chk("f4_w3",     {32'd0, cap_at(3)},  {30'd0, 1'b0, 1'b0, pack3(272, 273, 274)});
        chk("f4_w11",    {32'd0, cap_at(11)}, {30'd0, 1'b0, 1'b1, pack3(310, 311, 312)});
        chk("f4_lcnt",   {48'd0, line_count}, STATS_C ? 64'd4 : 64'd0);
        chk("f4_pcnt",   {48'd0, pix_count},  STATS_C ? 64'd9 : 64'd0);

        // ---------------- overflow: 12 words into 8 entries ----------------
        bus_if.out_ready = 1'b0;
        cap_q.delete();
        frame_start();
        for (int l = 0; l < 12; l++) send_line(3, 3 * l + 1, 1'b0);
        frame_end();
        chk("ov_flag",   {63'd0, overflow},         64'd1);
        chk("ov_valid",  {63'd0, bus_if.out_valid}, 64'd1);
        chk("ov_hold",   {30'd0, bus_if.out_sof, bus_if.out_eol, bus_if.out_data},
                         {30'd0, 1'b1, 1'b1, 32'h0030_0801});
        repeat (3) step();
        chk("ov_hold2",  {32'd0, bus_if.out_data}, 64'h0030_0801);
        chk("ov_none",   64'(cap_q.size()), 64'd0);
        bus_if.out_ready = 1'b1;
        repeat (12) step();
        chk("ov_nwords", 64'(cap_q.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ov_w%0d", k), {32'd0, cap_at(k)},
                {30'd0, (k == 0), 1'b1, pack3(3 * k + 1, 3 * k + 2, 3 * k + 3)});
        end
        chk("ov_sticky", {63'd0, overflow}, 64'd1);

        // ---------------- full FIFO with simultaneous read and write ----------------
        do_reset(1'b0);
        chk("sim_ovf0", {63'd0, overflow}, 64'd0);
        cap_q.delete();
        frame_start();
        for (int l = 0; l < 8; l++) send_line(3, 100 + 3 * l, 1'b0);
        send_line(3, 124, 1'b1);
        frame_end();
        chk("sim_ovf",   {63'd0, overflow}, 64'd0);
        chk("sim_pop",   64'(cap_q.size()), 64'd1);
        bus_if.out_ready = 1'b1;
        repeat (12) step();
        chk("sim_nwords", 64'(cap_q.size()), 64'd9);
        chk("sim_w0",     {32'd0, cap_at(0)}, {30'd0, 1'b1, 1'b1, pack3(100, 101, 102)});
        chk("sim_w8",     {32'd0, cap_at(8)}, {30'd0, 1'b0, 1'b1, pack3(124, 125, 126)});

        // ---------------- reset after the second pixel of a line ----------------
        cap_q.delete();
        frame_start();
        bus_if.cam_lval = 1'b1;
        bus_if.cam_d    = 10'h055;
        step();
        bus_if.cam_d    = 10'h066;
        step();
        reset           = 1'b1;
        bus_if.cam_lval = 1'b0;
        bus_if.cam_fval = 1'b0;
        bus_if.cam_d    = 10'd0;
        step();
        reset = 1'b0;
        repeat (5) step();
        chk("mr_nwords", 64'(cap_q.size()), 64'd0);
        chk("mr_valid",  {63'd0, bus_if.out_valid}, 64'd0);
        chk("mr_data",   {32'd0, bus_if.out_data},  64'd0);
        chk("mr_flags",  {62'd0, bus_if.out_sof, bus_if.out_eol}, 64'd0);
        chk("mr_ovf",    {63'd0, overflow},   64'd0);
        chk("mr_cnts",   {32'd0, line_count, pix_count}, 64'd0);
        frame_start();
        send_line(3, 33, 1'b0);
        frame_end();
        chk("mr_next", {32'd0, cap_at(0)}, {30'd0, 1'b1, 1'b1, 32'h0230_8821});

        // ---------------- reset released mid-frame ----------------
        do_reset(1'b1);
        bus_if.out_ready = 1'b1;
        cap_q.delete();
        repeat (3) step();
        send_line(3, 49, 1'b0);
        frame_end();
        chk("mf_nwords", 64'(cap_q.size()), 64'd0);
        chk("mf_valid",  {63'd0, bus_if.out_valid}, 64'd0);
        frame_start();
        send_line(3, 65, 1'b0);
        frame_end();
        chk("mf_next_n", 64'(cap_q.size()), 64'd1);
        chk("mf_next",   {32'd0, cap_at(0)}, {30'd0, 1'b1, 1'b1, 32'h0431_0841});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
